// File: rtl/tcm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tcmarb_pkg
// Shared types for the TCM port arbiter: requester-id type (sized for the
// largest supported requester count), read/write command encoding, and the
// default starvation threshold.
// -----------------------------------------------------------------------------
package tcmarb_pkg;

  localparam int NR_MAX         = 8;
  localparam int STARVE_DEFAULT = 8;

  // Wide enough for any requester index up to NR_MAX-1.
  typedef logic [$clog2(NR_MAX)-1:0] req_id_t;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  // Any byte enable set means write; all-zero means read.
  function automatic cmd_e cmd_of(input logic wr_any);
    return wr_any ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/tcm_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin priority encoder: returns the first set request at or after the
// pointer, wrapping modulo N.
// Ports:
//   i_req     in  N   request vector
//   i_ptr     in  id  starting position (must be < N)
//   o_onehot  out N   one-hot of the selected requester
//   o_idx     out id  index of the selected requester
//   o_any     out 1   at least one request set
// -----------------------------------------------------------------------------
module rr_pick
  import tcmarb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  req_id_t      i_ptr,
  output logic [N-1:0] o_onehot,
  output req_id_t      o_idx,
  output logic         o_any
);

  localparam int             IW  = $bits(req_id_t);
  localparam int             IW1 = IW + 1;
  localparam logic [N-1:0]   ONE = N'(1);
  localparam logic [IW1-1:0] NV  = IW1'(N);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_take;
  logic [N:0]   w_seen;
  req_id_t      w_pos     [N];
  logic [N-1:0] w_oh_acc  [N+1];
  req_id_t      w_idx_acc [N+1];

  assign w_seen[0]    = 1'b0;
  assign w_oh_acc[0]  = '0;
  assign w_idx_acc[0] = '0;

  // Slot gi examines requester (ptr + gi) mod N. Since ptr < N and gi < N,
  // one conditional subtract is enough for the modulo.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic [IW1-1:0] w_sum;
      assign w_sum          = {1'b0, i_ptr} + IW1'(gi);
      assign w_pos[gi]      = (w_sum >= NV) ? IW'(w_sum - NV) : IW'(w_sum);
      assign w_rot[gi]      = |(i_req & (ONE << w_pos[gi]));
      assign w_take[gi]     = w_rot[gi] & ~w_seen[gi];
      assign w_seen[gi+1]   = w_seen[gi] | w_rot[gi];
      assign w_oh_acc[gi+1] = w_oh_acc[gi] | (w_take[gi] ? (ONE << w_pos[gi]) : '0);
      assign w_idx_acc[gi+1] = w_idx_acc[gi] | (w_take[gi] ? w_pos[gi] : '0);
    end
  endgenerate

  assign o_onehot = w_oh_acc[N];
  assign o_idx    = w_idx_acc[N];
  assign o_any    = w_seen[N];

endmodule

// File: rtl/tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_arbiter
// Shares one TCM RAM port between NR requesters. Priority: starvation-promoted
// requesters (round-robin among them), then HP, then round-robin over the rest.
// Tracks the owner of the outstanding read and steers the read response back.
// Ports:
//   clk, resetn          clock, async active-low reset
//   req[NR]              requests, payload held until gnt
//   raddr[NR*AW]         per-requester word address (flattened)
//   rwr[NR*BC]           per-requester byte enables, zero = read
//   rwdata[NR*DW]        per-requester write data
//   gnt[NR]              one-hot accept strobe (combinational)
//   rvalid[NR]           one-hot read-data-valid
//   rdata[DW]            shared read data, qualified by rvalid
//   ramcs/ramaddr/ramwr/ramwdata  RAM command outputs
//   ramrdata/ramready    RAM read data and ready/wait-state input
// -----------------------------------------------------------------------------
module tcm_arbiter
  import tcmarb_pkg::*;
#(
  parameter int NR     = 3,
  parameter int AW     = 13,
  parameter int DW     = 36,
  parameter int BC     = 4,
  parameter int HP     = 0,
  parameter int STARVE = STARVE_DEFAULT,
  parameter int STW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NR-1:0]    req,
  input  logic [NR*AW-1:0] raddr,
  input  logic [NR*BC-1:0] rwr,
  input  logic [NR*DW-1:0] rwdata,
  output logic [NR-1:0]    gnt,
  output logic [NR-1:0]    rvalid,
  output logic [DW-1:0]    rdata,
  output logic             ramcs,
  output logic [AW-1:0]    ramaddr,
  output logic [BC-1:0]    ramwr,
  output logic [DW-1:0]    ramwdata,
  input  logic [DW-1:0]    ramrdata,
  input  logic             ramready
);

  localparam int              IDW      = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [NR-1:0]   ONE      = NR'(1);
  localparam logic [NR-1:0]   HP_MASK  = ONE << HP;
  localparam logic [STW-1:0]  STARVE_V = STW'(STARVE);
  localparam req_id_t         LAST_ID  = req_id_t'(NR - 1);

  logic [STW-1:0] r_cnt [NR];
  logic [IDW-1:0] r_rrptr;
  logic           r_pend_vld;
  req_id_t        r_pend_id;

  logic [NR-1:0]  w_prom, w_norm, w_prom_oh, w_norm_oh, w_win_oh;
  req_id_t        w_prom_idx, w_norm_idx, w_win;
  logic           w_prom_any, w_norm_any, w_accept;
  logic [BC-1:0]  w_win_wr;
  cmd_e           w_cmd;

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_starve
      assign w_prom[gi] = req[gi] & (r_cnt[gi] == STARVE_V);

      // Counts cycles spent waiting; any gap in the request restarts it.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt[gi] <= '0;
        end else if (!req[gi] || gnt[gi]) begin
          r_cnt[gi] <= '0;
        end else if (r_cnt[gi] != STARVE_V) begin
          r_cnt[gi] <= r_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign w_norm = req & ~HP_MASK;

  rr_pick #(.N(NR)) u_pick_prom (
    .i_req    (w_prom),
    .i_ptr    (req_id_t'(r_rrptr)),
    .o_onehot (w_prom_oh),
    .o_idx    (w_prom_idx),
    .o_any    (w_prom_any)
  );

  rr_pick #(.N(NR)) u_pick_norm (
    .i_req    (w_norm),
    .i_ptr    (req_id_t'(r_rrptr)),
    .o_onehot (w_norm_oh),
    .o_idx    (w_norm_idx),
    .o_any    (w_norm_any)
  );

  always_comb begin
    w_win    = w_norm_idx;
    w_win_oh = w_norm_oh;
    if (w_prom_any) begin
      w_win    = w_prom_idx;
      w_win_oh = w_prom_oh;
    end else if (|(req & HP_MASK)) begin
      w_win    = req_id_t'(HP);
      w_win_oh = HP_MASK;
    end
  end

  // Outputs are gated by resetn so the port is quiet for the whole reset.
  assign w_accept = resetn & ramready & (w_prom_any | (|(req & HP_MASK)) | w_norm_any);
  assign w_win_wr = rwr[w_win*BC +: BC];
  assign w_cmd    = cmd_of(|w_win_wr);

  always_comb begin
    gnt      = '0;
    ramcs    = 1'b0;
    ramaddr  = '0;
    ramwr    = '0;
    ramwdata = '0;
    if (w_accept) begin
      gnt      = w_win_oh;
      ramcs    = 1'b1;
      ramaddr  = raddr[w_win*AW +: AW];
      ramwr    = w_win_wr;
      ramwdata = rwdata[w_win*DW +: DW];
    end
  end

  assign rvalid = (r_pend_vld && ramready) ? (ONE << r_pend_id) : '0;
  assign rdata  = r_pend_vld ? ramrdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rrptr <= '0;
    end else if (w_accept) begin
      r_rrptr <= (w_win == LAST_ID) ? '0 : IDW'(w_win + 1'b1);
    end
  end

  // With ramready high the outstanding read (if any) completes this cycle,
  // so pend is either reloaded by a new read accept or emptied.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_vld <= 1'b0;
      r_pend_id  <= '0;
    end else if (ramready) begin
      if (w_accept) begin
        r_pend_vld <= (w_cmd == CMD_READ);
        if (w_cmd == CMD_READ) begin
          r_pend_id <= w_win;
        end
      end else begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcm_arbiter
// Directed bench for tcm_arbiter (NR=3, HP=0, STARVE=8): a per-cycle vector
// table followed by hand-written wait-state, read/write overlap, starvation
// and mid-transaction reset sequences.
// -----------------------------------------------------------------------------
module tb_tcm_arbiter;

  localparam int NR = 3;
  localparam int AW = 13;
  localparam int DW = 36;
  localparam int BC = 4;
  localparam logic [DW-1:0] W0 = 36'h123456780;
  localparam logic [DW-1:0] WB = 36'h9DEADBEEF;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] raddr;
  logic [NR*BC-1:0] rwr;
  logic [NR*DW-1:0] rwdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             ramcs;
  logic [AW-1:0]    ramaddr;
  logic [BC-1:0]    ramwr;
  logic [DW-1:0]    ramwdata;
  logic [DW-1:0]    ramrdata;
  logic             ramready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tcm_arbiter #(
    .NR(NR), .AW(AW), .DW(DW), .BC(BC), .HP(0), .STARVE(8), .STW(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .raddr    (raddr),
    .rwr      (rwr),
    .rwdata   (rwdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ramcs    (ramcs),
    .ramaddr  (ramaddr),
    .ramwr    (ramwr),
    .ramwdata (ramwdata),
    .ramrdata (ramrdata),
    .ramready (ramready)
  );

  // RAM stand-in: background content is a fixed function of the address,
  // overlaid by the most recent write.
  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return 36'hA50000000 | {23'd0, a};
  endfunction

  logic [AW-1:0] ram_ra = '0;
  logic [AW-1:0] ram_wa = '0;
  logic [DW-1:0] ram_wd = '0;
  logic          ram_wv = 1'b0;

  always @(posedge clk) begin
    if (ramcs) begin
      if (ramwr != '0) begin
        ram_wa <= ramaddr;
        ram_wd <= ramwdata;
        ram_wv <= 1'b1;
      end else begin
        ram_ra <= ramaddr;
      end
    end
  end

  assign ramrdata = (ram_wv && ram_ra == ram_wa) ? ram_wd : memval(ram_ra);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    raddr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++) rwr[i*BC +: BC] = m[i] ? 4'hF : 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] wr;
    logic          rdy;
    logic [NR-1:0] gnt;
    logic [NR-1:0] rvld;
    logic [AW-1:0] addr;
    logic [BC-1:0] wen;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
  } vec_t;

  function automatic vec_t mk(input logic [NR-1:0] rq, input logic [NR-1:0] wr,
                              input logic rdy, input logic [NR-1:0] g,
                              input logic [NR-1:0] rv, input logic [AW-1:0] a,
                              input logic [BC-1:0] wen, input logic [DW-1:0] wd,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.req = rq; v.wr = wr; v.rdy = rdy; v.gnt = g; v.rvld = rv;
    v.addr = a; v.wen = wen; v.wdat = wd; v.rdat = rd;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    int found;
    int hp_cnt;

    // Per-cycle vectors; requesters 0/1/2 read 0x10/0x20/0x30 unless noted.
    tbl[0]  = mk(3'b111, 3'b000, 1, 3'b001, 3'b000, 13'h010, 4'h0, '0, '0);
    tbl[1]  = mk(3'b110, 3'b000, 1, 3'b010, 3'b001, 13'h020, 4'h0, '0, memval(13'h010));
    tbl[2]  = mk(3'b100, 3'b000, 1, 3'b100, 3'b010, 13'h030, 4'h0, '0, memval(13'h020));
    tbl[3]  = mk(3'b001, 3'b000, 1, 3'b001, 3'b100, 13'h010, 4'h0, '0, memval(13'h030));
    tbl[4]  = mk(3'b000, 3'b000, 1, 3'b000, 3'b001, 13'h000, 4'h0, '0, memval(13'h010));
    tbl[5]  = mk(3'b000, 3'b000, 1, 3'b000, 3'b000, 13'h000, 4'h0, '0, '0);
    tbl[6]  = mk(3'b100, 3'b000, 1, 3'b100, 3'b000, 13'h030, 4'h0, '0, '0);
    tbl[7]  = mk(3'b001, 3'b000, 1, 3'b001, 3'b100, 13'h010, 4'h0, '0, memval(13'h030));
    tbl[8]  = mk(3'b000, 3'b000, 1, 3'b000, 3'b001, 13'h000, 4'h0, '0, memval(13'h010));
    tbl[9]  = mk(3'b110, 3'b000, 1, 3'b010, 3'b000, 13'h020, 4'h0, '0, '0);
    tbl[10] = mk(3'b110, 3'b000, 1, 3'b100, 3'b010, 13'h030, 4'h0, '0, memval(13'h020));
    tbl[11] = mk(3'b110, 3'b000, 1, 3'b010, 3'b100, 13'h020, 4'h0, '0, memval(13'h030));
    tbl[12] = mk(3'b000, 3'b000, 1, 3'b000, 3'b010, 13'h000, 4'h0, '0, memval(13'h020));
    tbl[13] = mk(3'b010, 3'b000, 0, 3'b000, 3'b000, 13'h000, 4'h0, '0, '0);
    tbl[14] = mk(3'b010, 3'b000, 1, 3'b010, 3'b000, 13'h020, 4'h0, '0, '0);
    tbl[15] = mk(3'b000, 3'b000, 0, 3'b000, 3'b000, 13'h000, 4'h0, '0, '0);
    tbl[16] = mk(3'b000, 3'b000, 1, 3'b000, 3'b010, 13'h000, 4'h0, '0, memval(13'h020));
    tbl[17] = mk(3'b001, 3'b001, 1, 3'b001, 3'b000, 13'h010, 4'hF, W0, '0);
    tbl[18] = mk(3'b000, 3'b000, 1, 3'b000, 3'b000, 13'h000, 4'h0, '0, '0);

    resetn   = 1'b0;
    req      = 3'b111;
    ramready = 1'b1;
    rwr      = '0;
    raddr    = '0;
    rwdata   = '0;
    for (int i = 0; i < NR; i++) begin
      set_addr(i, AW'(16 * (i + 1)));
      rwdata[i*DW +: DW] = W0 + DW'(i);
    end

    // Reset state with requests pending and the RAM ready.
    #4;
    check("reset_gnt", 64'(gnt), 0);
    check("reset_rvalid", 64'(rvalid), 0);
    check("reset_rdata", 64'(rdata), 0);
    check("reset_ramcs", 64'(ramcs), 0);
    check("reset_ramaddr", 64'(ramaddr), 0);
    @(posedge clk);
    next_cycle();
    resetn = 1'b1;
    req    = '0;

    for (int r = 0; r < 19; r++) begin
      req      = tbl[r].req;
      ramready = tbl[r].rdy;
      set_wr(tbl[r].wr);
      #3;
      check($sformatf("row%0d_gnt", r), 64'(gnt), 64'(tbl[r].gnt));
      check($sformatf("row%0d_rvalid", r), 64'(rvalid), 64'(tbl[r].rvld));
      check($sformatf("row%0d_ramcs", r), 64'(ramcs), 64'(tbl[r].gnt != '0));
      check($sformatf("row%0d_ramaddr", r), 64'(ramaddr), 64'(tbl[r].addr));
      check($sformatf("row%0d_ramwr", r), 64'(ramwr), 64'(tbl[r].wen));
      if (tbl[r].wen != '0)
        check($sformatf("row%0d_ramwdata", r), 64'(ramwdata), 64'(tbl[r].wdat));
      if (tbl[r].rvld != '0)
        check($sformatf("row%0d_rdata", r), 64'(rdata), 64'(tbl[r].rdat));
      next_cycle();
    end
    set_wr('0);

    // Two wait states on a read by requester 1; requester 0 must not be
    // granted while the RAM is stalled.
    set_addr(1, 13'h055);
    req = 3'b010; ramready = 1'b1;
    #3 check("ws_gnt_t", 64'(gnt), 64'(3'b010));
    next_cycle();
    req = 3'b001; ramready = 1'b0;
    #3 check("ws_gnt_t1", 64'(gnt), 0);
    check("ws_rvalid_t1", 64'(rvalid), 0);
    next_cycle();
    #3 check("ws_gnt_t2", 64'(gnt), 0);
    check("ws_rvalid_t2", 64'(rvalid), 0);
    next_cycle();
    ramready = 1'b1;
    #3 check("ws_rvalid_t3", 64'(rvalid), 64'(3'b010));
    check("ws_rdata_t3", 64'(rdata), 64'(memval(13'h055)));
    check("ws_gnt_t3", 64'(gnt), 64'(3'b001));
    next_cycle();
    req = '0;
    #3 check("ws_rvalid_t4", 64'(rvalid), 64'(3'b001));
    next_cycle();

    // Read by 0 followed directly by a write from 1.
    set_addr(0, 13'h021);
    req = 3'b001;
    #3 check("rw_gnt0", 64'(gnt), 64'(3'b001));
    next_cycle();
    set_addr(1, 13'h040);
    rwdata[1*DW +: DW] = WB;
    set_wr(3'b010);
    req = 3'b010;
    #3 check("rw_gnt1", 64'(gnt), 64'(3'b010));
    check("rw_ramwr", 64'(ramwr), 64'(4'hF));
    check("rw_ramwdata", 64'(ramwdata), 64'(WB));
    check("rw_rvalid0", 64'(rvalid), 64'(3'b001));
    check("rw_rdata0", 64'(rdata), 64'(memval(13'h021)));
    next_cycle();
    set_wr('0);
    req = '0;
    #3 check("rw_no_resp", 64'(rvalid), 0);
    next_cycle();
    set_addr(2, 13'h040);
    req = 3'b100;
    #3 check("rw_gnt2", 64'(gnt), 64'(3'b100));
    next_cycle();
    req = '0;
    #3 check("rw_readback_vld", 64'(rvalid), 64'(3'b100));
    check("rw_readback_data", 64'(rdata), 64'(WB));
    next_cycle();

    // HP requests every cycle while requester 2 is held.
    set_addr(0, 13'h010);
    set_addr(2, 13'h030);
    found  = -1;
    hp_cnt = 0;
    req    = 3'b101;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (gnt[2]) found = k;
      else if (gnt == 3'b001) hp_cnt++;
      next_cycle();
      if (found >= 0) break;
    end
    check("starve_latency", 64'(found), 64'(8));
    check("starve_hp_grants", 64'(hp_cnt), 64'(8));
    #3 check("starve_hp_after", 64'(gnt), 64'(3'b001));
    next_cycle();
    req = '0;
    next_cycle();

    // Reset one cycle after a read accept, RAM stalled for 3 cycles.
    set_addr(1, 13'h020);
    req = 3'b010;
    #3 check("rst_pre_gnt", 64'(gnt), 64'(3'b010));
    next_cycle();
    req = '0; ramready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_ramcs", 64'(ramcs), 0);
    check("rst_ramaddr", 64'(ramaddr), 0);
    check("rst_ramwr", 64'(ramwr), 0);
    check("rst_ramwdata", 64'(ramwdata), 0);
    ramready = 1'b1; req = 3'b111;
    #1;
    check("rst_hold_gnt", 64'(gnt), 0);
    check("rst_hold_ramcs", 64'(ramcs), 0);
    next_cycle();
    resetn = 1'b1; req = '0; ramready = 1'b0;
    #3 check("rst_drop_w1", 64'(rvalid), 0);
    next_cycle();
    #3 check("rst_drop_w2", 64'(rvalid), 0);
    next_cycle();
    ramready = 1'b1;
    #3 check("rst_drop_ready", 64'(rvalid), 0);
    next_cycle();
    req = 3'b110;
    #3 check("rst_ptr_zero", 64'(gnt), 64'(3'b010));
    next_cycle();
    req = '0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
